mux4_round_robin_arbiter: RTL and testbench
===========================================

# mux4_round_robin_arbiter

Sequences the shared 4-channel one-hot multiplexer between four requesters. Each requester raises a request line and holds it for as long as it needs the shared bus. The arbiter grants the bus round-robin and drives a registered one-hot grant straight into the Mux4 `selector` input. It inserts a one-cycle all-zero gap between owners so the mux output never carries two channels at once.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive BUSY cycles before preemption, used only when timeout is compiled in; legal range 1..(2^`CNT_WIDTH`).
- `CNT_WIDTH`, default 4: width of the hold counter.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  4: request vector; bit i high means requester i wants the bus.
- `grant`  out  4: registered one-hot grant (or all-zero); connects to Mux4 `selector`.
- `owner`  out  2: binary index of the current owner; valid only while `busy` is high.
- `busy`  out  1: high while a grant is active (state BUSY).
- `preempt`  out  1: one-cycle pulse when a grant is revoked by timeout. Tied 0 when timeout is compiled out.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: exactly one grant bit high.
  - GAP: one cycle, no grant.
- Round-robin pointer `ptr[1:0]`: the search starts at `ptr` and wraps upward, `ptr`, `ptr`+1 mod 4, and so on. The first set `req` bit wins.
- IDLE:
  - If `req` is non-zero, load the winner into `owner`, set `grant` to one-hot(winner), clear the hold counter, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - The hold counter increments each cycle and saturates at its maximum.
  - Release when `req[owner]` is sampled 0. Go to GAP, `grant` becomes 0, and `ptr` becomes `owner`+1 mod 4.
  - With timeout compiled in, preempt when the hold counter equals `MAX_HOLD`-1 and some other `req` bit is set. Go to GAP, `ptr` becomes `owner`+1, and `preempt` pulses for one cycle, aligned with the first GAP cycle.
  - A lone requester is never preempted; its counter keeps saturating.
- GAP:
  - Arbitrate exactly as in IDLE using the updated `ptr`. Go to BUSY on a winner, otherwise go to IDLE.
  - The preempted owner may win again only if no other requester is pending.
- Simultaneous release and timeout in the same cycle: treat it as a release; `preempt` stays 0.
- `req` bits other than the owner's are ignored while in BUSY.
- `grant` is always either one-hot or zero; it never has two bits set.

## Timing
- Grant latency: `req` sampled at edge N produces `grant` valid after edge N (visible in cycle N+1) when starting from IDLE.
- Turnaround: the owner drops `req` before edge N. Then `grant` is 0 in cycle N+1 (GAP) and the next owner's `grant` appears in cycle N+2.
- Reset values, asserted asynchronously:
  - state is IDLE
  - `grant` = 4'b0000
  - `owner` = 2'b00
  - `busy` = 0
  - `preempt` = 0
  - `ptr` = 0
  - hold counter = 0
- Reset asserted mid-grant drops `grant` immediately, without waiting for a clock edge.
- After reset deasserts, the first arbitration happens at the next rising edge.
- All outputs are registered; there is no combinational path from `req` to `grant`.

## Configuration
- `MUX4_ARB_TIMEOUT_EN` defined:
  - The hold counter compares against `MAX_HOLD` and can preempt the owner.
  - `preempt` is live.
- `MUX4_ARB_TIMEOUT_EN` undefined:
  - The owner keeps the bus until it drops `req`; there is no comparator.
  - `preempt` is constant 0.
  - The hold counter may be removed.

## Structure
- Shared package `mux4_arb_pkg`:
  - state enum constants `ST_IDLE`=2'd0, `ST_BUSY`=2'd1, `ST_GAP`=2'd2
  - `NUM_REQ`=4
  - `IDX_W`=2
- Sub-module `rr_pick`: purely combinational rotate/priority-select.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `any`, `win[1:0]`.
  - Instantiated once and shared by the IDLE and GAP paths.

## Test plan
- Reset mid-grant: assert `rst_n`=0 while `grant`=4'b0100 -> `grant`=0, `busy`=0 immediately; after release `req`=4'b0001 -> `grant`=4'b0001 one cycle later.
- Round-robin fairness: hold `req`=4'b1111, each owner drops `req` after 3 cycles and re-raises it in GAP -> grant order 0001, 0010, 0100, 1000, 0001, with exactly one zero cycle between owners.
- Single requester: `req`=4'b0100 held for 40 cycles (timeout on, `MAX_HOLD`=15) -> `grant`=4'b0100 continuously, `preempt` never pulses.
- Timeout preemption: owner 0 holds, `req`[2] rises at cycle 5 -> at the 15th BUSY cycle the next state is GAP with `preempt`=1 for one cycle, then `grant`=4'b0100.
- Release and timeout coincident: owner drops `req` exactly on the `MAX_HOLD`-1 cycle -> GAP entered, `preempt`=0.
- Timeout compiled out: repeat the preemption scenario -> owner 0 keeps `grant`=4'b0001 for all 40 cycles, `preempt` stays 0.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg
//   Shared constants and types for the Mux4 round-robin arbiter slice.
//   NUM_REQ  : number of requesters / mux channels
//   IDX_W    : width of a requester index
//   arb_state_e : FSM encoding (IDLE / BUSY / GAP)
//   onehot() : index -> one-hot select vector for the Mux4 selector
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] base;
        base = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return base << idx;
    endfunction

endpackage

// File: rtl/mux4_round_robin_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational round-robin select. Searches req starting at ptr
//   and wrapping upward; the first set bit wins.
//   req [3:0] : request vector
//   ptr [1:0] : search start index
//   any       : at least one request is set
//   win [1:0] : winning index (meaningless when any is 0)
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   win
);

    // Walk the offsets from farthest to nearest so the nearest set bit
    // (lowest offset from ptr) is the last assignment and therefore wins.
    always_comb begin
        any = |req;
        win = ptr;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (req[ptr + IDX_W'(k)]) begin
                win = ptr + IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux4_round_robin_arbiter.sv
// mux4_round_robin_arbiter
//   Round-robin arbiter driving the one-hot selector of a shared 4-channel
//   mux. A one-cycle all-zero GAP separates consecutive owners so the mux
//   output never carries two channels at once.
//
//   Parameters
//     MAX_HOLD  : max consecutive BUSY cycles before preemption (1..2^CNT_WIDTH)
//     CNT_WIDTH : hold counter width
//   Ports
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     req[3:0] : request vector, held by a requester while it needs the bus
//     grant[3:0]: registered one-hot grant (or zero), to Mux4 selector
//     owner[1:0]: current owner index, valid while busy
//     busy     : grant active (state BUSY)
//     preempt  : one-cycle pulse, aligned with the first GAP cycle, when the
//                owner was revoked by timeout
//
//   Configuration
//     MUX4_ARB_TIMEOUT_EN : when defined, an owner that has held the bus for
//                           MAX_HOLD cycles while someone else waits is
//                           preempted. When undefined, the owner keeps the bus
//                           until it drops req and preempt is constant 0.
module mux4_round_robin_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD  = 15,
    parameter int CNT_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   owner,
    output logic               busy,
    output logic               preempt
);

    if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_WIDTH)) begin : g_bad_max_hold
        $error("mux4_round_robin_arbiter: MAX_HOLD outside 1..2^CNT_WIDTH");
    end

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic [IDX_W-1:0]     owner_d;
    logic                 busy_d;
    logic                 preempt_d;

    logic                 pick_any;
    logic [IDX_W-1:0]     pick_win;

    logic                 release_w;
    logic                 timeout_w;

    // One picker serves both the IDLE and GAP arbitration paths.
    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .win (pick_win)
    );

    assign release_w = (state_q == ST_BUSY) && !req[owner];

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

    logic [CNT_WIDTH-1:0] hold_cnt_q;

    // Cleared whenever not BUSY, so it starts at 0 on the first BUSY cycle.
    // Saturates so a lone long-running owner never wraps back into range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if (state_q != ST_BUSY) begin
            hold_cnt_q <= '0;
        end else if (hold_cnt_q != {CNT_WIDTH{1'b1}}) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    // Requiring req[owner] makes a coincident release win over timeout.
    assign timeout_w = (state_q == ST_BUSY) && req[owner]
                     && (hold_cnt_q == HOLD_LAST)
                     && |(req & ~onehot(owner));
`else
    assign timeout_w = 1'b0;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant   <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant   <= grant_d;
            owner   <= owner_d;
            busy    <= busy_d;
            preempt <= preempt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_GAP:  state_d = pick_any ? ST_BUSY : ST_IDLE;
            ST_BUSY: if (release_w || timeout_w) state_d = ST_GAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and pointer
    always_comb begin
        grant_d   = '0;
        owner_d   = owner;
        busy_d    = 1'b0;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        case (state_q)
            ST_IDLE,
            ST_GAP: begin
                if (pick_any) begin
                    grant_d = onehot(pick_win);
                    owner_d = pick_win;
                    busy_d  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (release_w || timeout_w) begin
                    // Next search starts just past the leaving owner, so it
                    // only wins again if nobody else is waiting.
                    ptr_d     = owner + 1'b1;
                    preempt_d = timeout_w;
                end else begin
                    grant_d = grant;
                    busy_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mux4_round_robin_arbiter.sv
module tb_mux4_round_robin_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux4_round_robin_arbiter #(
        .MAX_HOLD  (15),
        .CNT_WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        int o;

        // Reset values
        #12;
        chk("rst_grant",   32'(grant),   32'h0);
        chk("rst_owner",   32'(owner),   32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);
        tick();
        rst_n = 1'b1;

        // Reset asserted mid-grant
        req = 4'b0100;
        tick();
        chk("mid_grant",  32'(grant), 32'h4);
        chk("mid_busy",   32'(busy),  32'h1);
        chk("mid_owner",  32'(owner), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_busy",  32'(busy),  32'h0);
        tick();
        rst_n = 1'b1;
        req   = 4'b0001;
        tick();
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        tick();
        chk("release_gap", 32'(grant), 32'h0);
        tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // Round-robin fairness with a one-cycle gap between owners
        reset_dut();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            o = n % 4;
            exp_g = 4'b0001 << o;
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("rr_grant", 32'(grant), 32'(exp_g));
                chk("rr_owner", 32'(owner), 32'(o));
            end
            req[o] = 1'b0;
            tick();
            chk("rr_gap", 32'(grant), 32'h0);
            req[o] = 1'b1;
        end

`ifdef MUX4_ARB_TIMEOUT_EN
        // Lone requester is never preempted
        reset_dut();
        req = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("lone_grant",   32'(grant),   32'h4);
            chk("lone_preempt", 32'(preempt), 32'h0);
        end

        // Timeout preemption at the 15th BUSY cycle
        reset_dut();
        req = 4'b0001;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("to_hold_grant",   32'(grant),   32'h1);
            chk("to_hold_preempt", 32'(preempt), 32'h0);
            if (i == 4) req = 4'b0101;
        end
        tick();
        chk("to_gap_grant",   32'(grant),   32'h0);
        chk("to_gap_preempt", 32'(preempt), 32'h1);
        chk("to_gap_busy",    32'(busy),    32'h0);
        tick();
        chk("to_next_grant",   32'(grant),   32'h4);
        chk("to_next_preempt", 32'(preempt), 32'h0);
        chk("to_next_owner",   32'(owner),   32'h2);

        // Release coincident with timeout counts as a release
        reset_dut();
        req = 4'b0101;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("co_hold_grant", 32'(grant), 32'h1);
        end
        req = 4'b0100;
        tick();
        chk("co_gap_grant",   32'(grant),   32'h0);
        chk("co_gap_preempt", 32'(preempt), 32'h0);
        tick();
        chk("co_next_grant", 32'(grant), 32'h4);
`else
        // Without timeout the owner keeps the bus while others wait
        reset_dut();
        req = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("noto_grant",   32'(grant),   32'h1);
            chk("noto_preempt", 32'(preempt), 32'h0);
            if (i == 3) req = 4'b0101;
        end
        req = 4'b0100;
        tick();
        chk("noto_gap", 32'(grant), 32'h0);
        tick();
        chk("noto_next", 32'(grant), 32'h4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
